qmf_synthesis_axis: RTL and testbench



---
 rtl/qmf_synthesis_axis.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_qmf_synthesis_axis.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qmf_synthesis_axis.sv
// Stereo 2-band QMF synthesis: joins low/high AXI-Stream bands and upsamples by 2 through a polyphase Q15 filter.
// Optional build macro QMF_SYN_ROUND_EN: round half up before the final >>>14 instead of floor truncation.
module qmf_synthesis_axis #(
    parameter int NTAPS              = 8,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 12
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [31:0]                     s_axis_low_tdata,
    input  logic                            s_axis_low_tvalid,
    output logic                            s_axis_low_tready,
    input  logic                            s_axis_low_tlast,
    input  logic [31:0]                     s_axis_high_tdata,
    input  logic                            s_axis_high_tvalid,
    output logic                            s_axis_high_tready,
    input  logic                            s_axis_high_tlast,
    output logic [31:0]                     m_axis_tdata,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tlast,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    output logic [1:0]                      s_axi_bresp,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready
);

    localparam int P    = NTAPS / 2;
    localparam int KW   = (P > 1) ? $clog2(P) : 1;
    localparam int CW   = $clog2(P + 2);
    localparam int ACCW = 34 + $clog2(P);
    localparam int WIW  = C_S_AXI_ADDR_WIDTH - 2;

    localparam logic [CW-1:0] CNT_P    = CW'(P);
    localparam logic [CW-1:0] CNT_LAST = CW'(P + 1);

    localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'(32767);
    localparam logic signed [ACCW-1:0] SAT_MIN = ACCW'(-32768);
    localparam logic signed [ACCW-1:0] RND_HALF = ACCW'(8192);

    typedef enum logic [1:0] {IDLE, MAC, OUT_EVEN, OUT_ODD} state_t;

    state_t state_reg, state_next;

    logic                   enable_reg;
    logic signed [15:0]     coef_reg [NTAPS];
    logic [CW-1:0]          mac_cnt_reg;
    logic                   tlast_reg;

    logic                   in_ready;
    logic                   accept;
    logic                   prod_en;
    logic                   acc_add;
    logic                   y_load;
    logic                   hist_clr;
    logic [KW-1:0]          tap_idx;
    logic signed [15:0]     coef_e;
    logic signed [15:0]     coef_o;
    logic [31:0]            y_even_w;
    logic [31:0]            y_odd_w;

    logic                   aw_ready_reg;
    logic                   b_valid_reg;
    logic                   ar_ready_reg;
    logic                   r_valid_reg;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_data_reg;
    logic [C_S_AXI_DATA_WIDTH-1:0] rd_mux;
    logic [WIW-1:0]         wr_idx;
    logic [WIW-1:0]         rd_idx;
    logic                   wr_fire;
    logic                   rd_fire;
    logic                   unused_ok;

    // Floor (or rounded) Q15 rescale of a doubled accumulator, clamped to 16 bits.
    function automatic logic signed [15:0] sat16(input logic signed [ACCW-1:0] acc);
        logic signed [ACCW-1:0] t;
`ifdef QMF_SYN_ROUND_EN
        t = (acc + RND_HALF) >>> 14;
`else
        t = acc >>> 14;
`endif
        if (t > SAT_MAX)
            return 16'sh7fff;
        else if (t < SAT_MIN)
            return 16'sh8000;
        else
            return t[15:0];
    endfunction

    // ---------------- control ----------------
    assign in_ready = enable_reg && (state_reg == IDLE);
    assign accept   = in_ready && s_axis_low_tvalid && s_axis_high_tvalid;
    assign prod_en  = (state_reg == MAC) && (mac_cnt_reg < CNT_P);
    assign acc_add  = (state_reg == MAC) && (mac_cnt_reg != '0) && (mac_cnt_reg <= CNT_P);
    assign y_load   = (state_reg == MAC) && (mac_cnt_reg == CNT_LAST);
    assign tap_idx  = mac_cnt_reg[KW-1:0];
    assign coef_e   = coef_reg[{tap_idx, 1'b0}];
    assign coef_o   = coef_reg[{tap_idx, 1'b1}];

    assign s_axis_low_tready  = in_ready;
    assign s_axis_high_tready = in_ready;

    always_ff @(posedge clk) begin
        if (rst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (accept) state_next = MAC;
            MAC:      if (mac_cnt_reg == CNT_LAST) state_next = OUT_EVEN;
            OUT_EVEN: if (m_axis_tready) state_next = OUT_ODD;
            OUT_ODD:  if (m_axis_tready) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Counter runs P product cycles plus two pipeline cycles (last accumulate, rescale).
    always_ff @(posedge clk) begin
        if (rst) begin
            mac_cnt_reg <= '0;
            tlast_reg   <= 1'b0;
        end else begin
            if (accept) begin
                mac_cnt_reg <= '0;
                tlast_reg   <= s_axis_low_tlast | s_axis_high_tlast;
            end else if (state_reg == MAC) begin
                mac_cnt_reg <= mac_cnt_reg + 1'b1;
            end
        end
    end

    assign m_axis_tvalid = (state_reg == OUT_EVEN) || (state_reg == OUT_ODD);
    assign m_axis_tdata  = (state_reg == OUT_ODD) ? y_odd_w : y_even_w;
    assign m_axis_tlast  = (state_reg == OUT_ODD) && tlast_reg;

    // ---------------- per-channel datapath (0 = L, 1 = R) ----------------
    for (genvar gi = 0; gi < 2; gi++) begin : gen_ch
        logic signed [15:0]     lo_smp;
        logic signed [15:0]     hi_smp;
        logic signed [16:0]     d_new;
        logic signed [16:0]     s_new;
        logic signed [16:0]     d_hist [P];
        logic signed [16:0]     s_hist [P];
        logic signed [32:0]     prod_e_reg;
        logic signed [32:0]     prod_o_reg;
        logic signed [ACCW-1:0] acc_e_reg;
        logic signed [ACCW-1:0] acc_o_reg;
        logic signed [15:0]     y_even_reg;
        logic signed [15:0]     y_odd_reg;

        assign lo_smp = s_axis_low_tdata[gi*16 +: 16];
        assign hi_smp = s_axis_high_tdata[gi*16 +: 16];
        assign d_new  = {lo_smp[15], lo_smp} - {hi_smp[15], hi_smp};
        assign s_new  = {lo_smp[15], lo_smp} + {hi_smp[15], hi_smp};

        always_ff @(posedge clk) begin
            if (rst || hist_clr) begin
                for (int i = 0; i < P; i++) begin
                    d_hist[i] <= '0;
                    s_hist[i] <= '0;
                end
            end else if (accept) begin
                d_hist[0] <= d_new;
                s_hist[0] <= s_new;
                for (int i = 1; i < P; i++) begin
                    d_hist[i] <= d_hist[i-1];
                    s_hist[i] <= s_hist[i-1];
                end
            end
        end

        // Products are registered one cycle ahead of the accumulate.
        always_ff @(posedge clk) begin
            if (rst) begin
                prod_e_reg <= '0;
                prod_o_reg <= '0;
                acc_e_reg  <= '0;
                acc_o_reg  <= '0;
                y_even_reg <= '0;
                y_odd_reg  <= '0;
            end else begin
                if (prod_en) begin
                    prod_e_reg <= 33'(coef_e) * 33'(d_hist[tap_idx]);
                    prod_o_reg <= 33'(coef_o) * 33'(s_hist[tap_idx]);
                end
                if (accept) begin
                    acc_e_reg <= '0;
                    acc_o_reg <= '0;
                end else if (acc_add) begin
                    acc_e_reg <= acc_e_reg + ACCW'(prod_e_reg);
                    acc_o_reg <= acc_o_reg + ACCW'(prod_o_reg);
                end
                if (y_load) begin
                    y_even_reg <= sat16(acc_e_reg);
                    y_odd_reg  <= sat16(acc_o_reg);
                end
            end
        end

        assign y_even_w[gi*16 +: 16] = y_even_reg;
        assign y_odd_w[gi*16 +: 16]  = y_odd_reg;
    end

    // ---------------- AXI4-Lite register file ----------------
    assign wr_idx  = s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
    assign rd_idx  = s_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];
    assign wr_fire = aw_ready_reg && s_axi_awvalid && s_axi_wvalid;
    assign rd_fire = ar_ready_reg && s_axi_arvalid;
    assign hist_clr = wr_fire && (wr_idx == '0) && s_axi_wdata[0] && !enable_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_ready_reg <= 1'b0;
            b_valid_reg  <= 1'b0;
        end else begin
            aw_ready_reg <= !aw_ready_reg && s_axi_awvalid && s_axi_wvalid && !b_valid_reg;
            if (wr_fire)
                b_valid_reg <= 1'b1;
            else if (s_axi_bready)
                b_valid_reg <= 1'b0;
        end
    end

    // Coefficients are frozen while the filter runs; the write is still acknowledged.
    always_ff @(posedge clk) begin
        if (rst) begin
            enable_reg <= 1'b0;
            for (int i = 0; i < NTAPS; i++)
                coef_reg[i] <= '0;
        end else if (wr_fire) begin
            if (wr_idx == '0) begin
                enable_reg <= s_axi_wdata[0];
            end else if (!enable_reg) begin
                for (int i = 0; i < NTAPS; i++)
                    if (wr_idx == WIW'(i + 1))
                        coef_reg[i] <= s_axi_wdata[15:0];
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        if (rd_idx == '0)
            rd_mux[0] = enable_reg;
        for (int i = 0; i < NTAPS; i++)
            if (rd_idx == WIW'(i + 1))
                rd_mux[15:0] = coef_reg[i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ar_ready_reg <= 1'b0;
            r_valid_reg  <= 1'b0;
            r_data_reg   <= '0;
        end else begin
            ar_ready_reg <= !ar_ready_reg && s_axi_arvalid && !r_valid_reg;
            if (rd_fire) begin
                r_valid_reg <= 1'b1;
                r_data_reg  <= rd_mux;
            end else if (s_axi_rready) begin
                r_valid_reg <= 1'b0;
            end
        end
    end

    assign s_axi_awready = aw_ready_reg;
    assign s_axi_wready  = aw_ready_reg;
    assign s_axi_bvalid  = b_valid_reg;
    assign s_axi_bresp   = 2'b00;
    assign s_axi_arready = ar_ready_reg;
    assign s_axi_rvalid  = r_valid_reg;
    assign s_axi_rdata   = r_data_reg;
    assign s_axi_rresp   = 2'b00;

    assign unused_ok = &{1'b0, s_axi_wdata[C_S_AXI_DATA_WIDTH-1:16],
                         s_axi_awaddr[1:0], s_axi_araddr[1:0]};

endmodule

// File: tb/tb_qmf_synthesis_axis.sv
// Directed bench for qmf_synthesis_axis: register map, impulse responses, saturation, join/backpressure, reset.
`timescale 1ns/1ps
module tb_qmf_synthesis_axis;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_axis_low_tdata, s_axis_high_tdata, m_axis_tdata;
    logic        s_axis_low_tvalid, s_axis_low_tready, s_axis_low_tlast;
    logic        s_axis_high_tvalid, s_axis_high_tready, s_axis_high_tlast;
    logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [11:0] s_axi_awaddr, s_axi_araddr;
    logic        s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
    logic [31:0] s_axi_wdata, s_axi_rdata;
    logic [1:0]  s_axi_bresp, s_axi_rresp;
    logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
    logic        s_axi_rvalid, s_axi_rready;

    int          checks = 0;
    int          errors = 0;
    logic [32:0] exp_q [$];
    int          coef_m [8];
    int          dh [2][4];
    int          sh [2][4];
    bit          model_on = 0;
    bit          rnd_ready = 0;

    int jt [8] = '{308, -2315, 2275, 16056, 16056, 2275, -2315, 308};
    int t3 [8] = '{-308, -2315, -2275, 16056, -16056, 2275, 2315, 308};

    always #5 clk = ~clk;

    qmf_synthesis_axis #(.NTAPS(8), .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(12)) dut (
        .clk(clk), .rst(rst),
        .s_axis_low_tdata(s_axis_low_tdata), .s_axis_low_tvalid(s_axis_low_tvalid),
        .s_axis_low_tready(s_axis_low_tready), .s_axis_low_tlast(s_axis_low_tlast),
        .s_axis_high_tdata(s_axis_high_tdata), .s_axis_high_tvalid(s_axis_high_tvalid),
        .s_axis_high_tready(s_axis_high_tready), .s_axis_high_tlast(s_axis_high_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
        .s_axi_rready(s_axi_rready)
    );

    function automatic logic [31:0] pack2(input int l, input int r);
        logic [31:0] x;
        x = {r[15:0], l[15:0]};
        return x;
    endfunction

    // Floor division by 2^14 then clamp to the signed 16-bit range.
    function automatic logic [15:0] sat_m(input longint a);
        longint q;
        q = a / 16384;
        if ((a % 16384) != 0 && a < 0) q = q - 1;
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
        return q[15:0];
    endfunction

    task automatic model_clear();
        for (int c = 0; c < 2; c++)
            for (int k = 0; k < 4; k++) begin
                dh[c][k] = 0;
                sh[c][k] = 0;
            end
    endtask

    task automatic model_push(input logic [31:0] lo, input logic [31:0] hi, input logic tl);
        logic [15:0] ye [2];
        logic [15:0] yo [2];
        longint acc_e, acc_o;
        int l, h;
        for (int ch = 0; ch < 2; ch++) begin
            l = int'($signed(lo[ch*16 +: 16]));
            h = int'($signed(hi[ch*16 +: 16]));
            for (int k = 3; k > 0; k--) begin
                dh[ch][k] = dh[ch][k-1];
                sh[ch][k] = sh[ch][k-1];
            end
            dh[ch][0] = l - h;
            sh[ch][0] = l + h;
            acc_e = 0;
            acc_o = 0;
            for (int k = 0; k < 4; k++) begin
                acc_e += 2 * longint'(coef_m[2*k]) * longint'(dh[ch][k]);
                acc_o += 2 * longint'(coef_m[2*k+1]) * longint'(sh[ch][k]);
            end
            ye[ch] = sat_m(acc_e / 2);
            yo[ch] = sat_m(acc_o / 2);
        end
        if (model_on) begin
            exp_q.push_back({1'b0, ye[1], ye[0]});
            exp_q.push_back({tl, yo[1], yo[0]});
        end
    endtask

    task automatic axi_write(input logic [11:0] addr, input logic [31:0] data, output logic [1:0] resp);
        bit got;
        @(posedge clk); #1;
        s_axi_awaddr = addr; s_axi_awvalid = 1'b1;
        s_axi_wdata = data;  s_axi_wvalid = 1'b1;
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = s_axi_awready && s_axi_wready;
        end
        checks++;
        assert (got === 1'b1) else begin errors++; $error("FAIL aw_handshake: got timeout want awready addr=%h", addr); end
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b1;
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = s_axi_bvalid;
        end
        checks++;
        assert (got === 1'b1) else begin errors++; $error("FAIL b_handshake: got timeout want bvalid addr=%h", addr); end
        resp = s_axi_bresp;
        @(posedge clk); #1;
        s_axi_bready = 1'b0;
        $display("axi write addr=%h data=%h bresp=%0d", addr, data, resp);
    endtask

    task automatic axi_read(input logic [11:0] addr, output logic [31:0] data);
        bit got;
        @(posedge clk); #1;
        s_axi_araddr = addr; s_axi_arvalid = 1'b1;
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = s_axi_arready;
        end
        checks++;
        assert (got === 1'b1) else begin errors++; $error("FAIL ar_handshake: got timeout want arready addr=%h", addr); end
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = s_axi_rvalid;
        end
        checks++;
        assert (got === 1'b1) else begin errors++; $error("FAIL r_handshake: got timeout want rvalid addr=%h", addr); end
        data = s_axi_rdata;
        @(posedge clk); #1;
        s_axi_rready = 1'b0;
        $display("axi read  addr=%h data=%h", addr, data);
    endtask

    // hold > 0: present low alone for that many cycles before joining with high.
    task automatic send_pair(input logic [31:0] lo, input logic [31:0] hi,
                             input logic tl_lo, input logic tl_hi, input int hold);
        bit got;
        model_push(lo, hi, tl_lo | tl_hi);
        @(posedge clk); #1;
        s_axis_low_tdata = lo;  s_axis_low_tlast = tl_lo;  s_axis_low_tvalid = 1'b1;
        s_axis_high_tdata = hi; s_axis_high_tlast = tl_hi;
        if (hold > 0) begin
            s_axis_high_tvalid = 1'b0;
            repeat (hold) @(negedge clk);
            checks++;
            assert (s_axis_low_tready === 1'b1 && m_axis_tvalid === 1'b0)
                else begin errors++; $error("FAIL join_hold: got tready=%b tvalid=%b want 1 0", s_axis_low_tready, m_axis_tvalid); end
            @(posedge clk); #1;
        end
        s_axis_high_tvalid = 1'b1;
        got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            got = s_axis_low_tready && s_axis_high_tready;
        end
        checks++;
        assert (got === 1'b1) else begin errors++; $error("FAIL accept: got timeout want tready lo=%h hi=%h", lo, hi); end
        @(posedge clk); #1;
        s_axis_low_tvalid = 1'b0; s_axis_high_tvalid = 1'b0;
        s_axis_low_tlast = 1'b0;  s_axis_high_tlast = 1'b0;
        $display("pair sent low=%h high=%h tlast=%b%b", lo, hi, tl_lo, tl_hi);
    endtask

    task automatic drain();
        for (int i = 0; i < 600 && exp_q.size() != 0; i++) @(negedge clk);
        checks++;
        assert (exp_q.size() == 0) else begin errors++; $error("FAIL drain: got %0d beats pending want 0", exp_q.size()); end
        repeat (3) @(posedge clk);
    endtask

    // m_axis_tready driver: always ready unless randomised backpressure is enabled.
    initial begin
        m_axis_tready = 1'b0;
        forever begin
            @(posedge clk); #1;
            m_axis_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor: scoreboard pop on each handshake, stability check while stalled.
    initial begin
        logic        stalled;
        logic [32:0] held, got_beat, want;
        stalled = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled = 1'b0;
            end else begin
                got_beat = {m_axis_tlast, m_axis_tdata};
                if (stalled) begin
                    checks++;
                    assert (m_axis_tvalid === 1'b1 && got_beat === held)
                        else begin errors++; $error("FAIL stall_hold: got v=%b %h want v=1 %h", m_axis_tvalid, got_beat, held); end
                end
                if (m_axis_tvalid === 1'b1 && m_axis_tready) begin
                    checks++;
                    assert (exp_q.size() != 0) else begin errors++; $error("FAIL extra_beat: got %h want no beat", got_beat); end
                    if (exp_q.size() != 0) begin
                        want = exp_q.pop_front();
                        checks++;
                        assert (got_beat === want)
                            else begin errors++; $error("FAIL beat: got last=%b data=%h want last=%b data=%h", got_beat[32], got_beat[31:0], want[32], want[31:0]); end
                        $display("beat last=%b data=%h", got_beat[32], got_beat[31:0]);
                    end
                end
                stalled = (m_axis_tvalid === 1'b1) && !m_axis_tready;
                held = got_beat;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  resp;
        logic [31:0] rd;
        int          lat;
        rst = 1'b1;
        s_axis_low_tdata = '0;  s_axis_low_tvalid = 1'b0;  s_axis_low_tlast = 1'b0;
        s_axis_high_tdata = '0; s_axis_high_tvalid = 1'b0; s_axis_high_tlast = 1'b0;
        s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wvalid = 1'b0;
        s_axi_bready = 1'b0; s_axi_araddr = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
        model_clear();
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++;
        assert ({s_axis_low_tready, s_axis_high_tready, m_axis_tvalid, m_axis_tlast} === 4'b0000)
            else begin errors++; $error("FAIL reset_stream: got %b want 0000", {s_axis_low_tready, s_axis_high_tready, m_axis_tvalid, m_axis_tlast}); end
        checks++;
        assert (m_axis_tdata === 32'h0) else begin errors++; $error("FAIL reset_tdata: got %h want 0", m_axis_tdata); end
        checks++;
        assert ({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid} === 5'b00000)
            else begin errors++; $error("FAIL reset_axil: got %b want 00000", {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid}); end
        @(posedge clk); #1;
        rst = 1'b0;

        // Register map: coefficients, unmapped address, enable.
        axi_read(12'h000, rd);
        checks++;
        assert (rd === 32'h0) else begin errors++; $error("FAIL enable_reset: got %h want 0", rd); end
        for (int i = 0; i < 8; i++) begin
            axi_write(12'(4 + 4*i), 32'(jt[i]), resp);
            coef_m[i] = jt[i];
        end
        checks++;
        assert (resp === 2'b00) else begin errors++; $error("FAIL bresp: got %0d want 0", resp); end
        for (int i = 0; i < 8; i++) begin
            axi_read(12'(4 + 4*i), rd);
            checks++;
            assert (rd === {16'd0, pack2(jt[i], 0)}) else begin errors++; $error("FAIL coef_rb%0d: got %h want %h", i, rd, {16'd0, pack2(jt[i], 0)}); end
        end
        axi_read(12'h024, rd);
        checks++;
        assert (rd === 32'h0) else begin errors++; $error("FAIL unmapped_rd: got %h want 0", rd); end
        axi_write(12'h000, 32'h1, resp);
        model_clear();
        axi_read(12'h000, rd);
        checks++;
        assert (rd === 32'h1) else begin errors++; $error("FAIL enable_rd: got %h want 1", rd); end

        // Low-band impulse: odd beat of the last pair carries tlast.
        for (int i = 0; i < 8; i++)
            exp_q.push_back({(i == 7) ? 1'b1 : 1'b0, pack2(jt[i], jt[i])});
        send_pair(32'h40004000, 32'h0, 1'b0, 1'b0, 0);
        lat = -1;
        for (int i = 0; i < 20 && lat < 0; i++) begin
            @(negedge clk);
            if (m_axis_tvalid === 1'b1) lat = i;
        end
        checks++;
        assert (lat === 6) else begin errors++; $error("FAIL latency: got %0d want 6", lat); end
        send_pair(32'h0, 32'h0, 1'b0, 1'b0, 0);
        send_pair(32'h0, 32'h0, 1'b0, 1'b0, 0);
        send_pair(32'h0, 32'h0, 1'b1, 1'b0, 0);
        drain();

        // High-band impulse: tlast from the high input on the first pair.
        for (int i = 0; i < 8; i++)
            exp_q.push_back({(i == 1) ? 1'b1 : 1'b0, pack2(t3[i], t3[i])});
        send_pair(32'h0, 32'h40004000, 1'b0, 1'b1, 0);
        for (int i = 0; i < 3; i++) send_pair(32'h0, 32'h0, 1'b0, 1'b0, 0);
        drain();

        // Coefficient write while enabled is acknowledged and ignored.
        axi_write(12'h004, 32'd1234, resp);
        checks++;
        assert (resp === 2'b00) else begin errors++; $error("FAIL bresp_enabled: got %0d want 0", resp); end
        axi_read(12'h004, rd);
        checks++;
        assert (rd === 32'd308) else begin errors++; $error("FAIL coef_locked: got %0d want 308", rd); end

        // Join hold, random data/tlast, random output backpressure.
        model_on = 1;
        rnd_ready = 1;
        send_pair(32'h12345678, 32'h0badcafe, 1'b0, 1'b0, 10);
        for (int i = 0; i < 12; i++)
            send_pair($urandom, $urandom, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0), 0);
        drain();
        rnd_ready = 0;
        model_on = 0;

        // Saturation: all-max coefficients, L=32767, H=-32768 on both channels.
        axi_write(12'h000, 32'h0, resp);
        for (int i = 0; i < 8; i++) begin
            axi_write(12'(4 + 4*i), 32'd32767, resp);
            coef_m[i] = 32767;
        end
        axi_write(12'h000, 32'h1, resp);
        model_clear();
        for (int i = 0; i < 5; i++) begin
            lat = (i < 4) ? -2 * (i + 1) : -8;
            exp_q.push_back({1'b0, pack2(32767, 32767)});
            exp_q.push_back({1'b0, pack2(lat, lat)});
        end
        for (int i = 0; i < 5; i++) send_pair(32'h7fff7fff, 32'h80008000, 1'b0, 1'b0, 0);
        drain();

        // Reset during MAC drops the pending pair.
        send_pair(32'h10001000, 32'h20002000, 1'b1, 1'b0, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        lat = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (m_axis_tvalid === 1'b1 || s_axis_low_tready === 1'b1) lat = 1;
        end
        checks++;
        assert (lat === 0) else begin errors++; $error("FAIL reset_midop: got activity=%0d want 0", lat); end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
